// File: rtl/uart_pkg.sv
// Shared link definitions for the btint matrix UART pair.
// Geometry, FSM states and element indexing live here so both link ends agree.
package uart_pkg;

   localparam int ROWS             = 4;
   localparam int COLS             = 4;
   localparam int DIGITS           = 8;
   localparam int DIGITS_PER_FRAME = 4;
   localparam int STOP_BITS        = 2;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP
   } rx_state_t;

   // Flat element slot: row 0 / column 0 sits in the most significant slot.
   function automatic logic [3:0] element_index(input logic [1:0] r, input logic [1:0] c);
      return 4'((ROWS - 1 - int'(r)) * COLS + (COLS - 1 - int'(c)));
   endfunction

endpackage

// File: rtl/uart_receiver_shift.sv
// Digit-pair deserializer: counts the 8 DATA bits of a frame and builds the
// a and b nibbles (even bit index -> a digit, odd bit index -> b digit).
module uart_receiver_shift
   import uart_pkg::*;
(
   input  logic                        uart_receiver_clock,
   input  logic                        uart_receiver_reset_active_low,
   input  logic                        shift_en,
   input  logic                        serial_bit,
   output logic [DIGITS_PER_FRAME-1:0] a_nibble,
   output logic [DIGITS_PER_FRAME-1:0] b_nibble,
   output logic                        last_bit
);

   logic [2:0] bit_idx;

   always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
      if (!uart_receiver_reset_active_low) begin
         bit_idx  <= '0;
         a_nibble <= '0;
         b_nibble <= '0;
      end else if (shift_en) begin
         if (bit_idx[0])
            b_nibble[bit_idx[2:1]] <= serial_bit;
         else
            a_nibble[bit_idx[2:1]] <= serial_bit;
         bit_idx <= bit_idx + 3'd1;
      end
   end

   assign last_bit = (bit_idx == 3'd7);

endmodule

// File: rtl/uart_receiver.sv
// Receives one 4x4 btint matrix column (two 11-bit frames per element) and
// commits each element into the held output matrix. Framing check is enabled
// by defining UART_RECEIVER_FRAMING_CHECK_EN.
module uart_receiver
   import uart_pkg::*;
(
   input  logic               uart_receiver_clock,
   input  logic               uart_receiver_reset_active_low,
   input  logic               uart_receiver_input,
   input  logic signed [31:0] uart_receiver_column,
   output logic [127:0]       uart_receiver_output_btint_a,
   output logic [127:0]       uart_receiver_output_btint_b,
   output logic [31:0]        uart_receiver_output_overflow,
   output logic               uart_receiver_output_valid,
   output logic               uart_receiver_framing_error
);

   rx_state_t          state, next_state;
   logic [1:0]         row;
   logic               half;
   logic               stop_cnt;
   logic signed [31:0] col_q;
   logic [DIGITS-1:0]  shadow_a, shadow_b;
   logic               elem_bad;
   logic [3:0]         a_nib, b_nib;
   logic               last_bit, shift_en, stop_bad, frame_done;

   logic               commit_q, commit_ok, commit_flag, last_col_q, stop_bad_q;
   logic [DIGITS-1:0]  commit_a, commit_b;
   logic [1:0]         commit_row, commit_col;
   logic [3:0]         elem_idx;
   logic [6:0]         digit_lsb;
   logic [4:0]         ovf_lsb;

   uart_receiver_shift u_shift (
      .uart_receiver_clock            (uart_receiver_clock),
      .uart_receiver_reset_active_low (uart_receiver_reset_active_low),
      .shift_en                       (shift_en),
      .serial_bit                     (uart_receiver_input),
      .a_nibble                       (a_nib),
      .b_nibble                       (b_nib),
      .last_bit                       (last_bit)
   );

   assign frame_done = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));

`ifdef UART_RECEIVER_FRAMING_CHECK_EN
   assign stop_bad = (state == STOP) && !uart_receiver_input;
`else
   assign stop_bad = 1'b0;
`endif

   always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
      if (!uart_receiver_reset_active_low)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      shift_en   = 1'b0;
      case (state)
         IDLE: if (!uart_receiver_input) next_state = DATA;
         DATA: begin
            shift_en = 1'b1;
            if (last_bit) next_state = STOP;
         end
         STOP: if (frame_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Element assembly; a finished element is staged one cycle before it hits the matrix.
   always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
      if (!uart_receiver_reset_active_low) begin
         row         <= '0;
         half        <= 1'b0;
         stop_cnt    <= 1'b0;
         col_q       <= '0;
         shadow_a    <= '0;
         shadow_b    <= '0;
         elem_bad    <= 1'b0;
         commit_q    <= 1'b0;
         commit_ok   <= 1'b0;
         commit_flag <= 1'b0;
         commit_a    <= '0;
         commit_b    <= '0;
         commit_row  <= '0;
         commit_col  <= '0;
         last_col_q  <= 1'b0;
         stop_bad_q  <= 1'b0;
      end else begin
         commit_q   <= 1'b0;
         last_col_q <= 1'b0;
         stop_bad_q <= stop_bad;
         if (state == IDLE && !uart_receiver_input && row == 2'd0 && !half)
            col_q <= uart_receiver_column;
         if (state == STOP) begin
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_cnt == 1'b0) begin
               shadow_a[{half, 2'b00} +: 4] <= a_nib;
               shadow_b[{half, 2'b00} +: 4] <= b_nib;
            end
            if (stop_bad) elem_bad <= 1'b1;
            if (frame_done) begin
               if (!half) begin
                  half <= 1'b1;
               end else begin
                  half        <= 1'b0;
                  row         <= row + 2'd1;
                  elem_bad    <= 1'b0;
                  commit_q    <= 1'b1;
                  commit_ok   <= (col_q >= 0) && (col_q <= 3);
                  commit_flag <= elem_bad | stop_bad;
                  commit_a    <= shadow_a;
                  commit_b    <= shadow_b;
                  commit_row  <= row;
                  commit_col  <= col_q[1:0];
                  last_col_q  <= (row == 2'd3);
               end
            end
         end
      end
   end

   assign elem_idx  = element_index(commit_row, commit_col);
   assign digit_lsb = {elem_idx, 3'b000};
   assign ovf_lsb   = {elem_idx, 1'b0};

   always_ff @(posedge uart_receiver_clock or negedge uart_receiver_reset_active_low) begin
      if (!uart_receiver_reset_active_low) begin
         uart_receiver_output_btint_a  <= '0;
         uart_receiver_output_btint_b  <= '0;
         uart_receiver_output_overflow <= '0;
         uart_receiver_output_valid    <= 1'b0;
         uart_receiver_framing_error   <= 1'b0;
      end else begin
         uart_receiver_output_valid  <= last_col_q;
         uart_receiver_framing_error <= stop_bad_q;
         if (commit_q && commit_ok) begin
            uart_receiver_output_btint_a[digit_lsb +: 8]  <= commit_a;
            uart_receiver_output_btint_b[digit_lsb +: 8]  <= commit_b;
            uart_receiver_output_overflow[ovf_lsb +: 2] <= commit_flag ? 2'b11 : 2'b00;
         end
      end
   end

endmodule
